// File: rtl/ws2812_frame_streamer.sv
// WS2812 frame buffer and G,R,B byte sequencer feeding the bit serialiser.
// Pixels are scaled by a per-frame brightness latched at frame start.
module ws2812_frame_streamer #(
  parameter int NUM_LEDS = 8,
  parameter int REFRESH_CYCLES = 0,
  localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [7:0]        brightness,
  input  logic              frame_start,
  output logic              trigger,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              data_request,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCALE,
    ST_SERVE,
    ST_END
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [23:0]       mem [NUM_LEDS];
  logic [23:0]       rd_q;
  logic [ADDR_W-1:0] pix_idx_q;
  logic [1:0]        byte_idx_q;
  logic [7:0]        bright_q;
  logic [7:0]        g_q;
  logic [7:0]        r_q;
  logic [7:0]        b_q;
  logic              first_q;
  logic              pending_q;
  logic              done_q;
  logic              tick;
  logic              go;
  logic              consume;
  logic              last_pix;
  logic              wr_ok;

  function automatic logic [7:0] scale(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return p[15:8];
  endfunction

  if (REFRESH_CYCLES > 0) begin : g_ref
    logic [31:0] cnt_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign tick = (cnt_q == 32'(REFRESH_CYCLES - 1));
  end else begin : g_noref
    assign tick = 1'b0;
  end

  assign go       = pending_q | frame_start;
  assign consume  = data_request & data_valid;
  assign last_pix = (32'(pix_idx_q) == 32'(NUM_LEDS - 1));
  assign wr_ok    = wr_en && (32'(wr_addr) < 32'(NUM_LEDS));

  // Plain RAM: no reset, writes accepted in every state.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_SCALE;
      end
      ST_SCALE: begin
        state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (consume && byte_idx_q == 2'd2) begin
          state_d = last_pix ? ST_END : ST_LOAD;
        end
      end
      ST_END: begin
        if (data_request) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= '0;
      pix_idx_q  <= '0;
      byte_idx_q <= '0;
      bright_q   <= '0;
      g_q        <= '0;
      r_q        <= '0;
      b_q        <= '0;
      first_q    <= 1'b0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_END) && data_request;
      // Leaving IDLE consumes the request; any later start re-arms it.
      if (state_q == ST_IDLE && go) begin
        pending_q <= 1'b0;
      end else if (frame_start || tick) begin
        pending_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            pix_idx_q <= '0;
            bright_q  <= brightness;
            first_q   <= 1'b1;
          end
        end
        ST_LOAD: begin
          rd_q <= mem[pix_idx_q];
        end
        ST_SCALE: begin
          r_q        <= scale(rd_q[23:16], bright_q);
          g_q        <= scale(rd_q[15:8], bright_q);
          b_q        <= scale(rd_q[7:0], bright_q);
          byte_idx_q <= '0;
        end
        ST_SERVE: begin
          if (consume) begin
            first_q <= 1'b0;
            if (byte_idx_q != 2'd2) begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end else if (!last_pix) begin
              pix_idx_q <= pix_idx_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (state_q == ST_SERVE) begin
      unique case (1'b1)
        byte_idx_q == 2'd0: data_out = g_q;
        byte_idx_q == 2'd1: data_out = r_q;
        default:            data_out = b_q;
      endcase
    end
  end

  assign data_valid = (state_q == ST_SERVE);
  assign trigger    = data_valid & first_q;
  assign busy       = (state_q != ST_IDLE) | pending_q;
  assign frame_done = done_q;

endmodule
